e_fwd_hazard_ctrl: RTL and testbench

- Consumer end of the forwarding path.
- Holds the E-stage operand register and receives the forwarded results that the M and W stages publish (M-stage forward data is ALU result or PC+8, W-stage is final write-back data).
- Performs per-cycle operand refresh by forwarding, and tracks destination register and Tnew for E/M/W.
- Generates the load-use / Tuse-vs-Tnew stall back to F/D, inserting a bubble into E.
- Sits between the D-stage register read and the E-stage ALU/MD inputs.

---
 rtl/e_fwd_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_e_fwd_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_fwd_hazard_ctrl.sv
// e_fwd_hazard_ctrl: E-stage operand register with M/W forwarding and Tuse/Tnew stall.
//
// Sits between the D-stage register read and the E-stage ALU/MD inputs. Tracks the
// destination register and remaining latency (Tnew) of the instructions in E, M and W,
// and raises a combinational stall back to F/D when a D-stage source cannot be served
// in time. A stall loads a bubble into E.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-low reset
//   D_*                 D-stage instruction fields and GRF read data
//   M_fwd_data          forward data published by M (ALU result or PC+8)
//   W_fwd_data          forward data published by W (final write-back data)
//   stall               hold PC and D register (combinational)
//   E_valid             E holds a real instruction
//   E_rs_val, E_rt_val  forwarded E operands (combinational from state + M/W data)
//   E/M/W_wr_addr       tracked destinations
//   E_tnew, M_tnew      tracked remaining latency
//   stall_cnt           saturating count of stall cycles (only with STALL_CNT_EN)
//
// Optional feature: define STALL_CNT_EN to add the stall_cnt port and counter.

module e_fwd_hazard_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D_valid,
  input  logic [ADDR_W-1:0] D_rs_addr,
  input  logic [ADDR_W-1:0] D_rt_addr,
  input  logic [DATA_W-1:0] D_rs_data,
  input  logic [DATA_W-1:0] D_rt_data,
  input  logic [ADDR_W-1:0] D_wr_addr,
  input  logic [1:0]        D_tnew,
  input  logic [1:0]        D_tuse_rs,
  input  logic [1:0]        D_tuse_rt,
  input  logic [DATA_W-1:0] M_fwd_data,
  input  logic [DATA_W-1:0] W_fwd_data,
  output logic              stall,
  output logic              E_valid,
  output logic [DATA_W-1:0] E_rs_val,
  output logic [DATA_W-1:0] E_rt_val,
  output logic [ADDR_W-1:0] E_wr_addr,
  output logic [ADDR_W-1:0] M_wr_addr,
  output logic [ADDR_W-1:0] W_wr_addr,
  output logic [1:0]        E_tnew,
  output logic [1:0]        M_tnew
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Tracked state
  logic              e_valid_q;
  logic [ADDR_W-1:0] e_rs_addr_q, e_rt_addr_q;
  logic [DATA_W-1:0] e_rs_q, e_rt_q;
  logic [ADDR_W-1:0] e_wr_addr_q, m_wr_addr_q, w_wr_addr_q;
  logic [1:0]        e_tnew_q, m_tnew_q;

  // M only forwards once its result exists (Tnew 0); M beats W because it is younger.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] held,
    input logic [ADDR_W-1:0] m_wr,
    input logic [1:0]        m_tnew,
    input logic [DATA_W-1:0] m_data,
    input logic [ADDR_W-1:0] w_wr,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] r;
    r = held;
    if (a != '0 && m_wr == a && m_tnew == 2'd0) begin
      r = m_data;
    end else if (a != '0 && w_wr == a) begin
      r = w_data;
    end
    return r;
  endfunction

  // Hazard detection; W never stalls since its data is always ready.
  logic stall_rs, stall_rt;

  always_comb begin
    stall_rs = D_valid && (D_rs_addr != '0) &&
               (((e_wr_addr_q == D_rs_addr) && (e_tnew_q > D_tuse_rs)) ||
                ((m_wr_addr_q == D_rs_addr) && (m_tnew_q > D_tuse_rs)));
    stall_rt = D_valid && (D_rt_addr != '0) &&
               (((e_wr_addr_q == D_rt_addr) && (e_tnew_q > D_tuse_rt)) ||
                ((m_wr_addr_q == D_rt_addr) && (m_tnew_q > D_tuse_rt)));
  end

  assign stall = stall_rs | stall_rt;

  // Forwarded values for the E operands and for the D operands being loaded this cycle.
  logic [DATA_W-1:0] e_rs_fwd, e_rt_fwd, d_rs_fwd, d_rt_fwd;

  always_comb begin
    e_rs_fwd = fwd_sel(e_rs_addr_q, e_rs_q, m_wr_addr_q, m_tnew_q, M_fwd_data,
                       w_wr_addr_q, W_fwd_data);
    e_rt_fwd = fwd_sel(e_rt_addr_q, e_rt_q, m_wr_addr_q, m_tnew_q, M_fwd_data,
                       w_wr_addr_q, W_fwd_data);
    d_rs_fwd = fwd_sel(D_rs_addr, D_rs_data, m_wr_addr_q, m_tnew_q, M_fwd_data,
                       w_wr_addr_q, W_fwd_data);
    d_rt_fwd = fwd_sel(D_rt_addr, D_rt_data, m_wr_addr_q, m_tnew_q, M_fwd_data,
                       w_wr_addr_q, W_fwd_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid_q   <= 1'b0;
      e_rs_addr_q <= '0;
      e_rt_addr_q <= '0;
      e_rs_q      <= '0;
      e_rt_q      <= '0;
      e_wr_addr_q <= '0;
      e_tnew_q    <= 2'd0;
      m_wr_addr_q <= '0;
      m_tnew_q    <= 2'd0;
      w_wr_addr_q <= '0;
    end else begin
      if (stall) begin
        // Bubble: zeroed source addresses keep the bubble's operands out of forwarding.
        e_valid_q   <= 1'b0;
        e_rs_addr_q <= '0;
        e_rt_addr_q <= '0;
        e_rs_q      <= '0;
        e_rt_q      <= '0;
        e_wr_addr_q <= '0;
        e_tnew_q    <= 2'd0;
      end else begin
        e_valid_q   <= D_valid;
        e_rs_addr_q <= D_rs_addr;
        e_rt_addr_q <= D_rt_addr;
        e_rs_q      <= d_rs_fwd;
        e_rt_q      <= d_rt_fwd;
        e_wr_addr_q <= D_wr_addr;
        e_tnew_q    <= D_tnew;
      end
      m_wr_addr_q <= e_wr_addr_q;
      m_tnew_q    <= (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      w_wr_addr_q <= m_wr_addr_q;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign E_valid   = e_valid_q;
  assign E_rs_val  = e_rs_fwd;
  assign E_rt_val  = e_rt_fwd;
  assign E_wr_addr = e_wr_addr_q;
  assign M_wr_addr = m_wr_addr_q;
  assign W_wr_addr = w_wr_addr_q;
  assign E_tnew    = e_tnew_q;
  assign M_tnew    = m_tnew_q;

endmodule

// File: tb/tb_e_fwd_hazard_ctrl.sv
// tb_e_fwd_hazard_ctrl: directed bench for e_fwd_hazard_ctrl. Each step drives the D/M/W
// inputs, queues the outputs expected for that cycle, and the queue is drained and
// compared at the following falling edge.

module tb_e_fwd_hazard_ctrl;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // Output selectors for the scoreboard
  localparam int SelStall  = 0;
  localparam int SelEValid = 1;
  localparam int SelERs    = 2;
  localparam int SelERt    = 3;
  localparam int SelEWr    = 4;
  localparam int SelMWr    = 5;
  localparam int SelWWr    = 6;
  localparam int SelETnew  = 7;
  localparam int SelMTnew  = 8;
  localparam int SelCnt    = 9;

  logic              clk;
  logic              reset;
  logic              D_valid;
  logic [ADDR_W-1:0] D_rs_addr, D_rt_addr, D_wr_addr;
  logic [DATA_W-1:0] D_rs_data, D_rt_data;
  logic [1:0]        D_tnew, D_tuse_rs, D_tuse_rt;
  logic [DATA_W-1:0] M_fwd_data, W_fwd_data;
  logic              stall, E_valid;
  logic [DATA_W-1:0] E_rs_val, E_rt_val;
  logic [ADDR_W-1:0] E_wr_addr, M_wr_addr, W_wr_addr;
  logic [1:0]        E_tnew, M_tnew;
`ifdef STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  e_fwd_hazard_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_valid    (D_valid),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_rs_data  (D_rs_data),
    .D_rt_data  (D_rt_data),
    .D_wr_addr  (D_wr_addr),
    .D_tnew     (D_tnew),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .M_fwd_data (M_fwd_data),
    .W_fwd_data (W_fwd_data),
    .stall      (stall),
    .E_valid    (E_valid),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .E_wr_addr  (E_wr_addr),
    .M_wr_addr  (M_wr_addr),
    .W_wr_addr  (W_wr_addr),
    .E_tnew     (E_tnew),
    .M_tnew     (M_tnew)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] r;
    r = 32'hxxxx_xxxx;
    case (sel)
      SelStall:  r = {31'd0, stall};
      SelEValid: r = {31'd0, E_valid};
      SelERs:    r = E_rs_val;
      SelERt:    r = E_rt_val;
      SelEWr:    r = {27'd0, E_wr_addr};
      SelMWr:    r = {27'd0, M_wr_addr};
      SelWWr:    r = {27'd0, W_wr_addr};
      SelETnew:  r = {30'd0, E_tnew};
      SelMTnew:  r = {30'd0, M_tnew};
`ifdef STALL_CNT_EN
      SelCnt:    r = stall_cnt;
`endif
      default:   r = 32'hxxxx_xxxx;
    endcase
    return r;
  endfunction

  task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare everything queued for the current cycle, then advance one clock.
  task automatic tick();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [4:0] wr, input logic [1:0] tnew,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt);
    D_valid   = v;
    D_rs_addr = rs;
    D_rt_addr = rt;
    D_rs_data = rsd;
    D_rt_data = rtd;
    D_wr_addr = wr;
    D_tnew    = tnew;
    D_tuse_rs = tu_rs;
    D_tuse_rt = tu_rt;
  endtask

  task automatic set_idle();
    set_d(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 2'd0, 2'd3, 2'd3);
  endtask

  task automatic set_fwd(input logic [31:0] m, input logic [31:0] w);
    M_fwd_data = m;
    W_fwd_data = w;
  endtask

  initial begin
    // Reset with random inputs: every output must read zero.
    reset = 1'b0;
    set_d(1'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 5'($urandom),
          2'($urandom), 2'($urandom), 2'($urandom));
    set_fwd($urandom, $urandom);
    tick();
    exp_push("rst_stall", SelStall, 32'd0);
    exp_push("rst_e_valid", SelEValid, 32'd0);
    exp_push("rst_e_rs", SelERs, 32'd0);
    exp_push("rst_e_rt", SelERt, 32'd0);
    exp_push("rst_e_wr", SelEWr, 32'd0);
    exp_push("rst_m_wr", SelMWr, 32'd0);
    exp_push("rst_w_wr", SelWWr, 32'd0);
    exp_push("rst_e_tnew", SelETnew, 32'd0);
    exp_push("rst_m_tnew", SelMTnew, 32'd0);
`ifdef STALL_CNT_EN
    exp_push("rst_cnt", SelCnt, 32'd0);
`endif
    tick();

    reset = 1'b1;
    set_idle();
    set_fwd(32'd0, 32'd0);
    exp_push("post_rst_stall", SelStall, 32'd0);
    tick();

    // ALU producer of $8 (tnew 1) followed by an add reading $8 (tuse 1).
    set_d(1'b1, 5'd1, 5'd2, 32'd0, 32'd0, 5'd8, 2'd1, 2'd1, 2'd1);
    exp_push("alu_prod_stall", SelStall, 32'd0);
    tick();
    set_d(1'b1, 5'd8, 5'd0, 32'hDEAD, 32'd0, 5'd10, 2'd1, 2'd1, 2'd1);
    exp_push("alu_use_stall", SelStall, 32'd0);
    exp_push("alu_e_wr", SelEWr, 32'd8);
    exp_push("alu_e_tnew", SelETnew, 32'd1);
    tick();
    set_idle();
    set_fwd(32'h1234, 32'h9999);
    exp_push("alu_fwd_m", SelERs, 32'h1234);
    exp_push("alu_rt_r0", SelERt, 32'd0);
    exp_push("alu_e_valid", SelEValid, 32'd1);
    exp_push("alu_m_wr", SelMWr, 32'd8);
    exp_push("alu_m_tnew", SelMTnew, 32'd0);
    tick();

    // lw $9 (tnew 2) then an ALU use of $9 (tuse 1): a single stall cycle.
    set_fwd(32'd0, 32'd0);
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 2'd2, 2'd3, 2'd3);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 32'd0, 32'd0, 5'd11, 2'd1, 2'd1, 2'd1);
    exp_push("ld_use_stall1", SelStall, 32'd1);
    exp_push("ld_e_tnew", SelETnew, 32'd2);
    tick();
    exp_push("ld_use_stall2", SelStall, 32'd0);
    exp_push("ld_bubble_valid", SelEValid, 32'd0);
    exp_push("ld_bubble_wr", SelEWr, 32'd0);
    exp_push("ld_bubble_rs", SelERs, 32'd0);
    exp_push("ld_m_wr", SelMWr, 32'd9);
    exp_push("ld_m_tnew", SelMTnew, 32'd1);
    tick();
    // The bubble sits in M now, so the load result reaches the consumer from W.
    set_idle();
    set_fwd(32'h0BAD, 32'hCAFE);
    exp_push("ld_use_val", SelERs, 32'hCAFE);
    exp_push("ld_use_valid", SelEValid, 32'd1);
    exp_push("ld_w_wr", SelWWr, 32'd9);
`ifdef STALL_CNT_EN
    exp_push("ld_cnt", SelCnt, 32'd1);
`endif
    tick();

    // Reset pulse so the branch test starts with a clean counter.
    reset = 1'b0;
    set_fwd(32'd0, 32'd0);
    tick();
    reset = 1'b1;
    exp_push("rst2_m_wr", SelMWr, 32'd0);
`ifdef STALL_CNT_EN
    exp_push("rst2_cnt", SelCnt, 32'd0);
`endif
    tick();

    // lw $9 then beq on $9 (tuse 0): two stall cycles.
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 2'd2, 2'd3, 2'd3);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 32'd0, 32'd0, 5'd0, 2'd0, 2'd0, 2'd3);
    exp_push("br_stall1", SelStall, 32'd1);
    tick();
    exp_push("br_stall2", SelStall, 32'd1);
    exp_push("br_m_tnew", SelMTnew, 32'd1);
    exp_push("br_bubble", SelEValid, 32'd0);
    tick();
    exp_push("br_stall3", SelStall, 32'd0);
    exp_push("br_m_wr", SelMWr, 32'd0);
`ifdef STALL_CNT_EN
    exp_push("br_cnt", SelCnt, 32'd2);
`endif
    tick();

    // Two producers of $4 in M and W, consumer reads $4 on both operands.
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd4, 2'd1, 2'd3, 2'd3);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd4, 2'd1, 2'd3, 2'd3);
    tick();
    set_d(1'b1, 5'd4, 5'd4, 32'd0, 32'd0, 5'd12, 2'd1, 2'd1, 2'd1);
    exp_push("mw_stall", SelStall, 32'd0);
    tick();
    set_idle();
    set_fwd(32'h11, 32'h22);
    exp_push("mw_prio_rs", SelERs, 32'h11);
    exp_push("mw_prio_rt", SelERt, 32'h11);
    exp_push("mw_m_wr", SelMWr, 32'd4);
    exp_push("mw_w_wr", SelWWr, 32'd4);
    tick();

    // Register 0: a load "to $0" must neither stall nor forward into a $0 reader.
    set_fwd(32'h0BAD, 32'h0BAD);
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 2'd2, 2'd3, 2'd3);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 32'h77, 32'h88, 5'd0, 2'd1, 2'd1, 2'd1);
    exp_push("r0_stall", SelStall, 32'd0);
    tick();
    set_idle();
    exp_push("r0_rs_held", SelERs, 32'h77);
    exp_push("r0_rt_held", SelERt, 32'h88);
    tick();

    // Producer of $5 only visible in W when the consumer loads; value kept afterwards.
    set_fwd(32'd0, 32'd0);
    set_d(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 2'd1, 2'd3, 2'd3);
    tick();
    set_idle();
    tick();
    tick();
    set_d(1'b1, 5'd5, 5'd0, 32'd0, 32'd0, 5'd13, 2'd1, 2'd1, 2'd3);
    set_fwd(32'h44, 32'h55);
    exp_push("ref_stall", SelStall, 32'd0);
    exp_push("ref_w_wr", SelWWr, 32'd5);
    tick();
    set_idle();
    set_fwd(32'h77, 32'h66);
    exp_push("ref_kept", SelERs, 32'h55);
    exp_push("ref_w_gone", SelWWr, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
